prf_free_list: RTL

Free-list manager for the physical register file: tracks which physical register indices are unallocated, hands up to two new destination indices per cycle to rename/dispatch, and accepts up to two released indices per cycle from retirement. On a branch mispredict it restores the list to its architectural state in one cycle. It sits between the rename stage and the reorder buffer (ROB) and owns the allocation of every PRF entry that the functional units later read.

---
 rtl/prf_free_list.sv | 98 +++++++++
 1 files changed

// File: rtl/prf_free_list.sv
// Physical register free list: circular buffer of unallocated PRF indices.
// Hands out up to two indices per cycle (all-or-nothing), accepts up to two
// released indices per cycle, and restores the at-rest list in one cycle on
// a mispredict flush.
module prf_free_list #(
    parameter int PRF_SIZE  = 64,
    parameter int ARF_SIZE  = 32,
    parameter int PRF_IDX_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           id_alloc_num,
    output logic                 alloc_gnt,
    output logic [PRF_IDX_W-1:0] alloc_idx0,
    output logic [PRF_IDX_W-1:0] alloc_idx1,
    input  logic [1:0]           rob_free_num,
    input  logic [PRF_IDX_W-1:0] rob_free_idx0,
    input  logic [PRF_IDX_W-1:0] rob_free_idx1,
    input  logic                 rob_flush,
    output logic [PRF_IDX_W:0]   free_cnt,
    output logic                 overflow_err
);

    localparam int FREE_AT_REST = PRF_SIZE - ARF_SIZE;
    // One extra bit over the count so an overflow past PRF_SIZE is visible.
    localparam int SUM_W = PRF_IDX_W + 2;

    logic [PRF_IDX_W-1:0] list_q [PRF_SIZE];
    logic [PRF_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PRF_IDX_W-1:0] head_p1, tail_p1, tail_adv;
    logic [PRF_IDX_W:0]   count_q, count_d;
    logic                 err_q, err_d;
    logic [1:0]           n_eff, m_eff, n_gnt;
    logic [SUM_W-1:0]     cnt_sum;

    // A request/release of 3 is clamped to the two available lanes.
    assign n_eff = (id_alloc_num == 2'd3) ? 2'd2 : id_alloc_num;
    assign m_eff = (rob_free_num == 2'd3) ? 2'd2 : rob_free_num;

    assign head_p1  = head_q + PRF_IDX_W'(1);
    assign tail_p1  = tail_q + PRF_IDX_W'(1);
    assign tail_adv = tail_q + PRF_IDX_W'(m_eff);

    // Grant only against the registered count: same-cycle frees never feed
    // allocation, which keeps the grant path short.
    assign alloc_gnt  = !rob_flush &&
                        ((n_eff == 2'd0) || (count_q >= (PRF_IDX_W+1)'(n_eff)));
    assign n_gnt      = alloc_gnt ? n_eff : 2'd0;
    assign alloc_idx0 = list_q[head_q];
    assign alloc_idx1 = list_q[head_p1];

    assign cnt_sum = SUM_W'(count_q) - SUM_W'(n_gnt) + SUM_W'(m_eff);

    assign free_cnt     = count_q;
    assign overflow_err = err_q;

    // Next-state pointers and count. On flush the in-flight entries are the
    // FREE_AT_REST... most recent pops, so rewinding head to tail-FREE_AT_REST
    // (after this cycle's frees) reclaims exactly them.
    always_comb begin
        tail_d  = tail_adv;
        head_d  = head_q + PRF_IDX_W'(n_gnt);
        count_d = cnt_sum[PRF_IDX_W:0];
        err_d   = err_q | (cnt_sum > SUM_W'(PRF_SIZE));
        if (rob_flush) begin
            head_d  = tail_adv - PRF_IDX_W'(FREE_AT_REST);
            count_d = (PRF_IDX_W+1)'(FREE_AT_REST);
        end
    end

    // Pointer, count and sticky error registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= PRF_IDX_W'(FREE_AT_REST);
            count_q <= (PRF_IDX_W+1)'(FREE_AT_REST);
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // List storage: reset holds ARF_SIZE.. in the first slots; released
    // indices are pushed at tail, the older one first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PRF_SIZE; i++)
                list_q[i] <= (i < FREE_AT_REST) ? PRF_IDX_W'(ARF_SIZE + i) : '0;
        end else begin
            if (m_eff != 2'd0) list_q[tail_q]  <= rob_free_idx0;
            if (m_eff == 2'd2) list_q[tail_p1] <= rob_free_idx1;
        end
    end

endmodule
